// File: rtl/shift_pkg.sv
// Shared definitions for the serial shifters in this block family.
// Holds the default word width, the counter width that goes with it and
// the two-state collect FSM encoding. The parallel-load shifter imports
// the same package.
package shift_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W      = $clog2(WORD_W_DEF);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/collect_bit.sv
// One stage of the collect shift register.
// Ports:
//   clk      - rising-edge clock
//   clear    - synchronous clear, wins over shift_en
//   shift_en - load d on this edge
//   d        - neighbour's output (or the serial input for the MSB stage)
//   q        - stored bit
module collect_bit (
  input  logic clk,
  input  logic clear,
  input  logic shift_en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 1'b0;
    end else if (shift_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_collector8.sv
// Serial-to-parallel collector: assembles WORD_W serial bits (LSB first)
// into a word and presents it on a single-entry valid/ready output slot.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   bit_in          - serial data bit
//   bit_valid       - bit_in is taken on this edge
//   flush           - abort the partial word (wins over bit_valid)
//   clear_overrun   - clear the sticky overrun flag
//   data_ready      - consumer accepts data_out on this edge
//   data_out        - last completed word
//   data_valid      - data_out holds an unconsumed word
//   busy            - partial word held (FSM is in COLLECT)
//   bit_count       - bits collected so far in the current word
//   overrun         - sticky: a completed word was dropped
//
// Output handshake: a word transfers on every edge where data_valid and
// data_ready are both 1. While data_valid=1 and data_ready=0, data_out and
// data_valid hold; a word completing then is dropped and sets overrun.
module shift_collector8
  import shift_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  input  logic                      flush,
  input  logic                      clear_overrun,
  input  logic                      data_ready,
  output logic [WORD_W-1:0]         data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic [$clog2(WORD_W)-1:0] bit_count,
  output logic                      overrun
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  state_t          state, state_n;
  logic [CW-1:0]   count_n;
  logic [WORD_W-1:0] collect;
  logic [WORD_W-1:0] shift_in;
  logic            accept;
  logic            final_bit;
  logic            slot_free;

  assign accept    = bit_valid & ~flush;
  assign final_bit = accept & (bit_count == LAST);
  // The slot can take a new word if it is empty or being emptied this edge.
  assign slot_free = ~data_valid | data_ready;

  // Right-shift view: bit_in enters the MSB, so the first bit lands at bit 0
  // after WORD_W shifts. This vector is also the completed word on the
  // final bit, since it already includes that bit.
  assign shift_in = {bit_in, collect[WORD_W-1:1]};

  for (genvar i = 0; i < WORD_W; i++) begin : g_collect
    collect_bit u_bit (
      .clk      (clk),
      .clear    (reset | flush),
      .shift_en (accept),
      .d        (shift_in[i]),
      .q        (collect[i])
    );
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_count <= '0;
    end else begin
      state     <= state_n;
      bit_count <= count_n;
    end
  end

  // FSM next state and counter
  always_comb begin
    state_n = state;
    count_n = bit_count;
    if (flush) begin
      state_n = IDLE;
      count_n = '0;
    end else if (accept) begin
      if (final_bit) begin
        state_n = IDLE;
        count_n = '0;
      end else begin
        state_n = COLLECT;
        count_n = bit_count + 1'b1;
      end
    end
  end

  // busy is the FSM state itself, visible on the port.
  assign busy = (state == COLLECT);

  // Output slot and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (final_bit && slot_free) begin
        data_out   <= shift_in;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      // A drop on the same edge as clear_overrun leaves the flag set.
      if (final_bit && !slot_free) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
